// File: rtl/seat_pkg.sv
// ============================================================================
// Module   : seat_pkg
// Purpose  : Shared request opcodes, response codes and FSM states for
//            seat_table.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package seat_pkg;

  typedef enum logic [1:0] {
    READ      = 2'b00,
    ASSIGN    = 2'b01,
    RELEASE   = 2'b10,
    CLEAR_ALL = 2'b11
  } seat_op_e;

  typedef enum logic [1:0] {
    OK        = 2'b00,
    OCCUPIED  = 2'b01,
    DUPLICATE = 2'b10,
    BAD_SEAT  = 2'b11
  } seat_status_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    SCAN = 2'b01,
    RESP = 2'b10
  } seat_state_e;

endpackage

`default_nettype wire

// File: rtl/seat_dup_scan.sv
// ============================================================================
// Module   : seat_dup_scan
// Purpose  : Walks the seat table one entry per cycle looking for an occupied
//            seat that already holds the captured student number.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seat_dup_scan
  import seat_pkg::*;
#(
  parameter  int SEATS  = 32,
  parameter  int ID_W   = 32,
  localparam int SEAT_W = $clog2(SEATS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              active,
  input  logic [ID_W-1:0]   student,
  input  logic [ID_W-1:0]   entry_id,
  input  logic              entry_valid,
  output logic [SEAT_W-1:0] idx,
  output logic              match,
  output logic              done
);

  localparam logic [SEAT_W-1:0] c_last = SEAT_W'(SEATS - 1);

  logic [SEAT_W-1:0] r_idx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx <= '0;
    end else if (start) begin
      r_idx <= '0;
    end else if (active && !match && !done) begin
      r_idx <= r_idx + SEAT_W'(1);
    end
  end

  assign idx   = r_idx;
  assign match = active && entry_valid && (entry_id == student);
  assign done  = active && (r_idx == c_last);

endmodule

`default_nettype wire

// File: rtl/seat_table.sv
// ============================================================================
// Module   : seat_table
// Purpose  : Seat-to-student table with occupancy bitmap and free counter,
//            driven by a valid/ready request port. Define
//            SEAT_TABLE_DUP_CHECK_EN to reject duplicate student numbers.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seat_table
  import seat_pkg::*;
#(
  parameter  int SEATS  = 32,
  parameter  int ID_W   = 32,
  localparam int SEAT_W = $clog2(SEATS)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic [1:0]                 req_op,
  input  logic [SEAT_W-1:0]          req_seat,
  input  logic [ID_W-1:0]            req_student,
  output logic                       rsp_valid,
  output logic [1:0]                 rsp_status,
  output logic [ID_W-1:0]            rsp_student,
  output logic [SEATS-1:0]           occupied,
  output logic [$clog2(SEATS+1)-1:0] free_count,
  output logic                       full,
  output logic                       empty
);

  localparam int                 c_cnt_w     = $clog2(SEATS + 1);
  localparam logic [c_cnt_w-1:0] c_seats_cnt = c_cnt_w'(SEATS);

  seat_state_e        r_state, w_next_state;
  logic [ID_W-1:0]    r_table [SEATS];
  logic [SEATS-1:0]   r_occ;
  logic [c_cnt_w-1:0] r_free_count;
  seat_status_e       r_rsp_status, w_rsp_status;
  logic [ID_W-1:0]    r_rsp_student, w_rsp_student;
  logic               w_rsp_load, w_commit, w_release, w_clear;
  logic [SEAT_W-1:0]  w_wr_seat;
  logic [ID_W-1:0]    w_wr_student;
  logic               w_seat_bad;
  seat_op_e           w_op;

  assign w_op       = seat_op_e'(req_op);
  assign w_seat_bad = (w_op != CLEAR_ALL) && (32'(req_seat) >= 32'(SEATS));

`ifdef SEAT_TABLE_DUP_CHECK_EN
  logic [SEAT_W-1:0] r_seat;
  logic [ID_W-1:0]   r_student;
  logic              w_scan_start, w_match, w_done;
  logic [SEAT_W-1:0] w_scan_idx;

  // The scan outlives the request cycle, so the target must be held here.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seat    <= '0;
      r_student <= '0;
    end else if (r_state == IDLE && req_valid) begin
      r_seat    <= req_seat;
      r_student <= req_student;
    end
  end

  seat_dup_scan #(
    .SEATS (SEATS),
    .ID_W  (ID_W)
  ) u_dup_scan (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (w_scan_start),
    .active      (r_state == SCAN),
    .student     (r_student),
    .entry_id    (r_table[w_scan_idx]),
    .entry_valid (r_occ[w_scan_idx]),
    .idx         (w_scan_idx),
    .match       (w_match),
    .done        (w_done)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_next_state;
  end

  always_comb begin
    w_next_state  = r_state;
    w_rsp_load    = 1'b0;
    w_rsp_status  = OK;
    w_rsp_student = '0;
    w_commit      = 1'b0;
    w_release     = 1'b0;
    w_clear       = 1'b0;
    w_wr_seat     = req_seat;
    w_wr_student  = req_student;
`ifdef SEAT_TABLE_DUP_CHECK_EN
    w_scan_start  = 1'b0;
`endif
    unique case (r_state)
      IDLE: begin
        if (req_valid) begin
          w_next_state = RESP;
          w_rsp_load   = 1'b1;
          if (w_seat_bad) begin
            w_rsp_status = BAD_SEAT;
          end else begin
            case (w_op)
              READ:      w_rsp_student = r_occ[req_seat] ? r_table[req_seat] : '0;
              ASSIGN: begin
                if (r_occ[req_seat]) begin
                  w_rsp_status = OCCUPIED;
                end else begin
`ifdef SEAT_TABLE_DUP_CHECK_EN
                  w_next_state = SCAN;
                  w_rsp_load   = 1'b0;
                  w_scan_start = 1'b1;
`else
                  w_commit     = 1'b1;
`endif
                end
              end
              RELEASE:   w_release = 1'b1;
              CLEAR_ALL: w_clear   = 1'b1;
              default:   ;
            endcase
          end
        end
      end
`ifdef SEAT_TABLE_DUP_CHECK_EN
      SCAN: begin
        if (w_match) begin
          w_next_state = RESP;
          w_rsp_load   = 1'b1;
          w_rsp_status = DUPLICATE;
        end else if (w_done) begin
          w_next_state = RESP;
          w_rsp_load   = 1'b1;
          w_commit     = 1'b1;
          w_wr_seat    = r_seat;
          w_wr_student = r_student;
        end
      end
`endif
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  // Table contents are deliberately not reset; r_occ masks stale entries.
  always_ff @(posedge clk) begin
    if (w_commit) r_table[w_wr_seat] <= w_wr_student;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_occ         <= '0;
      r_free_count  <= c_seats_cnt;
      r_rsp_status  <= OK;
      r_rsp_student <= '0;
    end else begin
      if (w_clear) begin
        r_occ        <= '0;
        r_free_count <= c_seats_cnt;
      end else if (w_commit) begin
        r_occ[w_wr_seat] <= 1'b1;
        r_free_count     <= r_free_count - c_cnt_w'(1);
      end else if (w_release) begin
        r_occ[req_seat] <= 1'b0;
        if (r_occ[req_seat]) r_free_count <= r_free_count + c_cnt_w'(1);
      end
      if (w_rsp_load) begin
        r_rsp_status  <= w_rsp_status;
        r_rsp_student <= w_rsp_student;
      end
    end
  end

  assign req_ready   = (r_state == IDLE);
  assign rsp_valid   = (r_state == RESP);
  assign rsp_status  = r_rsp_status;
  assign rsp_student = r_rsp_student;
  assign occupied    = r_occ;
  assign free_count  = r_free_count;
  assign full        = (r_free_count == '0);
  assign empty       = (r_free_count == c_seats_cnt);

endmodule

`default_nettype wire

// File: tb/tb_seat_table.sv
// ============================================================================
// Module   : tb_seat_table
// Purpose  : Directed and random checks of seat_table against a seat-array
//            reference model; also exercises a 20-seat instance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seat_table;

  localparam int S = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'd0;
  logic [4:0]  req_seat = 5'd0;
  logic [31:0] req_student = 32'd0;
  logic        rsp_valid;
  logic [1:0]  rsp_status;
  logic [31:0] rsp_student;
  logic [31:0] occupied;
  logic [5:0]  free_count;
  logic        full, empty;

  logic        b_valid = 1'b0;
  logic        b_ready;
  logic [1:0]  b_op = 2'd0;
  logic [4:0]  b_seat = 5'd0;
  logic [31:0] b_student = 32'd0;
  logic        b_rsp_valid;
  logic [1:0]  b_rsp_status;
  logic [31:0] b_rsp_student;
  logic [19:0] b_occupied;
  logic [4:0]  b_free_count;
  logic        b_full, b_empty;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_tab [S];
  logic [31:0] m_occ = '0;

  always #5 clk = ~clk;

  seat_table #(.SEATS(S), .ID_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_seat(req_seat), .req_student(req_student),
    .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_student(rsp_student),
    .occupied(occupied), .free_count(free_count), .full(full), .empty(empty)
  );

  seat_table #(.SEATS(20), .ID_W(32)) dut20 (
    .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
    .req_op(b_op), .req_seat(b_seat), .req_student(b_student),
    .rsp_valid(b_rsp_valid), .rsp_status(b_rsp_status), .rsp_student(b_rsp_student),
    .occupied(b_occupied), .free_count(b_free_count), .full(b_full), .empty(b_empty)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour: returns the expected response and latency, updates the model.
  task automatic model(input logic [1:0] op, input logic [4:0] seat, input logic [31:0] stu,
                       output logic [1:0] st, output logic [31:0] dat, output int lat);
    int hit;
    st  = 2'd0;
    dat = 32'd0;
    lat = 1;
    hit = -1;
    case (op)
      2'd0: dat = m_occ[seat] ? m_tab[seat] : 32'd0;
      2'd1: begin
        if (m_occ[seat]) begin
          st = 2'd1;
        end else begin
`ifdef SEAT_TABLE_DUP_CHECK_EN
          for (int i = S - 1; i >= 0; i--)
            if (m_occ[i] && m_tab[i] == stu) hit = i;
`endif
          if (hit >= 0) begin
            st  = 2'd2;
            lat = 2 + hit;
          end else begin
            m_occ[seat] = 1'b1;
            m_tab[seat] = stu;
`ifdef SEAT_TABLE_DUP_CHECK_EN
            lat = S + 1;
`endif
          end
        end
      end
      2'd2: m_occ[seat] = 1'b0;
      default: m_occ = '0;
    endcase
  endtask

  task automatic run_req(input logic [1:0] op, input logic [4:0] seat, input logic [31:0] stu);
    logic [1:0]  e_st;
    logic [31:0] e_dat;
    int          e_lat, lat, e_free;
    model(op, seat, stu, e_st, e_dat, e_lat);
    e_free = S - $countones(m_occ);
    @(negedge clk);
    check("ready_before", req_ready, 1);
    req_valid = 1'b1; req_op = op; req_seat = seat; req_student = stu;
    @(posedge clk); #1;
    // Scramble inputs after accept: the captured request must be used.
    req_valid = 1'b0; req_op = 2'($urandom); req_seat = 5'($urandom); req_student = $urandom;
    lat = 1;
    while (!rsp_valid && lat < S + 8) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat, e_lat);
    if (rsp_valid) begin
      check("status", rsp_status, e_st);
      check("student", rsp_student, e_dat);
    end
    check("occupied", occupied, m_occ);
    check("free_count", free_count, e_free);
    check("full", full, e_free == 0);
    check("empty", empty, e_free == S);
    @(posedge clk); #1;
    check("rsp_pulse", rsp_valid, 0);
    check("ready_after", req_ready, 1);
  endtask

  task automatic req20(input logic [1:0] op, input logic [4:0] seat, input logic [31:0] stu,
                       output logic [1:0] st);
    int lat;
    @(negedge clk);
    b_valid = 1'b1; b_op = op; b_seat = seat; b_student = stu;
    @(posedge clk); #1;
    b_valid = 1'b0;
    lat = 1;
    while (!b_rsp_valid && lat < 30) begin
      @(posedge clk); #1;
      lat++;
    end
    check("s20_rsp_seen", b_rsp_valid, 1);
    st = b_rsp_status;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"}, req_ready, 1);
    check({tag, "_rsp_valid"}, rsp_valid, 0);
    check({tag, "_rsp_status"}, rsp_status, 0);
    check({tag, "_rsp_student"}, rsp_student, 0);
    check({tag, "_occupied"}, occupied, 0);
    check({tag, "_free_count"}, free_count, S);
    check({tag, "_empty"}, empty, 1);
    check({tag, "_full"}, full, 0);
  endtask

  initial begin
    logic [1:0] st;
    int         seen;
    int         r;

    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed sequence
    run_req(2'd0, 5'd5, 32'd0);
    run_req(2'd1, 5'd3, 32'h2021_0001);
    run_req(2'd0, 5'd3, 32'd0);
    check("occ_seat3", occupied, 32'h0000_0008);
    run_req(2'd1, 5'd3, 32'h2021_0002);
    run_req(2'd0, 5'd3, 32'd0);
    run_req(2'd1, 5'd7, 32'h2021_0001);

    for (int i = 0; i < S; i++) run_req(2'd1, 5'(i), 32'h3000_0000 + 32'(i));
    check("full_after_fill", full, 1);
    check("free_after_fill", free_count, 0);
    run_req(2'd2, 5'd31, 32'd0);
    check("free_after_rel1", free_count, 1);
    run_req(2'd2, 5'd31, 32'd0);
    check("free_after_rel2", free_count, 1);
    run_req(2'd3, 5'd0, 32'd0);
    check("free_after_clear", free_count, S);
    run_req(2'd0, 5'd0, 32'd0);

    // Random traffic with a small ID pool so duplicates are common
    for (int k = 0; k < 250; k++) begin
      r = $urandom_range(0, 19);
      if (r < 6)       run_req(2'd0, 5'($urandom_range(0, S - 1)), 32'd0);
      else if (r < 14) run_req(2'd1, 5'($urandom_range(0, S - 1)),
                               32'h5000_0000 + 32'($urandom_range(0, 11)));
      else if (r < 19) run_req(2'd2, 5'($urandom_range(0, S - 1)), 32'd0);
      else             run_req(2'd3, 5'($urandom_range(0, S - 1)), 32'd0);
    end

    // 20-seat instance: range checks at and beyond the last seat
    req20(2'd1, 5'd19, 32'h0000_1919, st);
    check("s20_assign19", st, 2'd0);
    req20(2'd1, 5'd25, 32'h0000_2525, st);
    check("s20_assign25", st, 2'd3);
    check("s20_occ_kept", b_occupied, 20'h8_0000);
    req20(2'd0, 5'd20, 32'd0, st);
    check("s20_read20", st, 2'd3);
    req20(2'd2, 5'd31, 32'd0, st);
    check("s20_release31", st, 2'd3);
    check("s20_free", b_free_count, 19);

    // Reset in the middle of an ASSIGN
    run_req(2'd3, 5'd0, 32'd0);
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1; req_seat = 5'd9; req_student = 32'hABCD_0000;
    @(posedge clk); #1;
    req_valid = 1'b0;
    seen = 0;
    repeat (9) begin
      @(posedge clk); #1;
      if (rsp_valid) seen++;
    end
`ifdef SEAT_TABLE_DUP_CHECK_EN
    check("midscan_no_rsp", seen, 0);
`endif
    rst_n = 1'b0;
    m_occ = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset2");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("post_reset_ready", req_ready, 1);
    check("post_reset_seat9", occupied[9], 0);
    run_req(2'd0, 5'd9, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
